// File: rtl/edge_endpoint_if.sv
// Handshake bundle between an edge endpoint, its local client and the mesh edge port.
// The slave modport is the endpoint's view; master is the view of whoever drives it.
interface edge_endpoint_if #(
  parameter int COORD_WIDTH = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TX_DEPTH    = 4
);
  localparam int FW = 2*COORD_WIDTH + DATA_WIDTH;
  localparam int LW = $clog2(TX_DEPTH) + 1;

  logic                   tx_valid;
  logic                   tx_ready;
  logic [COORD_WIDTH-1:0] tx_dst_x;
  logic [COORD_WIDTH-1:0] tx_dst_y;
  logic [DATA_WIDTH-1:0]  tx_data;

  logic                   mesh_out_valid;
  logic                   mesh_out_ready;
  logic [FW-1:0]          mesh_out_flit;

  logic                   mesh_in_valid;
  logic                   mesh_in_ready;
  logic [FW-1:0]          mesh_in_flit;

  logic                   rx_valid;
  logic                   rx_ready;
  logic [DATA_WIDTH-1:0]  rx_data;

  logic [7:0]             drop_count;
  logic [LW-1:0]          tx_level;

  modport slave (
    input  tx_valid, tx_dst_x, tx_dst_y, tx_data, mesh_out_ready,
           mesh_in_valid, mesh_in_flit, rx_ready,
    output tx_ready, mesh_out_valid, mesh_out_flit, mesh_in_ready,
           rx_valid, rx_data, drop_count, tx_level
  );

  modport master (
    output tx_valid, tx_dst_x, tx_dst_y, tx_data, mesh_out_ready,
           mesh_in_valid, mesh_in_flit, rx_ready,
    input  tx_ready, mesh_out_valid, mesh_out_flit, mesh_in_ready,
           rx_valid, rx_data, drop_count, tx_level
  );
endinterface

// File: rtl/edge_endpoint.sv
// Mesh edge endpoint: TX FIFO packing local packets into flits, RX skid buffer
// accepting flits addressed to (X,Y) and counting misrouted ones.
module edge_endpoint #(
  parameter int X           = 0,
  parameter int Y           = 0,
  parameter int COORD_WIDTH = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TX_DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  edge_endpoint_if.slave bus
);
  localparam int FW = 2*COORD_WIDTH + DATA_WIDTH;
  localparam int AW = $clog2(TX_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [COORD_WIDTH-1:0] LP_X = COORD_WIDTH'(X);
  localparam logic [COORD_WIDTH-1:0] LP_Y = COORD_WIDTH'(Y);

  logic [FW-1:0] r_tx_mem [TX_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_tx_level;
  logic          w_tx_ready;
  logic          w_out_valid;
  logic          w_tx_push;
  logic          w_tx_pop;

  // Readiness depends only on occupancy, so a full FIFO refuses even while popping.
  assign w_tx_ready  = (r_tx_level != LW'(TX_DEPTH));
  assign w_out_valid = (r_tx_level != '0);
  assign w_tx_push   = bus.tx_valid && w_tx_ready;
  assign w_tx_pop    = w_out_valid && bus.mesh_out_ready;

  assign bus.tx_ready       = w_tx_ready;
  assign bus.mesh_out_valid = w_out_valid;
  assign bus.mesh_out_flit  = r_tx_mem[r_rd_ptr];
  assign bus.tx_level       = r_tx_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_tx_level <= '0;
    end else begin
      if (w_tx_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_tx_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_level <= r_tx_level + LW'(1);
        2'b01:   r_tx_level <= r_tx_level - LW'(1);
        default: r_tx_level <= r_tx_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_wr_ptr] <= {bus.tx_dst_x, bus.tx_dst_y, bus.tx_data};
  end

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} rx_state_t;

  rx_state_t             r_rx_state;
  rx_state_t             w_rx_state_nxt;
  logic [DATA_WIDTH-1:0] r_rx_head;
  logic [DATA_WIDTH-1:0] r_rx_tail;
  logic [7:0]            r_drop_count;
  logic                  w_in_ready;
  logic                  w_rx_valid;
  logic                  w_in_accept;
  logic                  w_match;
  logic                  w_store;
  logic                  w_rx_pop;
  logic                  w_head_from_in;
  logic                  w_head_from_tail;
  logic                  w_tail_from_in;

  assign w_in_ready  = (r_rx_state != S_TWO);
  assign w_rx_valid  = (r_rx_state != S_EMPTY);
  assign w_in_accept = bus.mesh_in_valid && w_in_ready;
  assign w_match     = (bus.mesh_in_flit[FW-1 -: COORD_WIDTH] == LP_X) &&
                       (bus.mesh_in_flit[FW-COORD_WIDTH-1 -: COORD_WIDTH] == LP_Y);
  assign w_store     = w_in_accept && w_match;
  assign w_rx_pop    = w_rx_valid && bus.rx_ready;

  assign bus.mesh_in_ready = w_in_ready;
  assign bus.rx_valid      = w_rx_valid;
  assign bus.rx_data       = r_rx_head;
  assign bus.drop_count    = r_drop_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state   <= S_EMPTY;
      r_drop_count <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      if (w_in_accept && !w_match && (r_drop_count != 8'hFF))
        r_drop_count <= r_drop_count + 8'd1;
    end
  end

  // Head always holds the oldest payload; tail only fills while the head is stalled.
  always_comb begin
    w_rx_state_nxt   = r_rx_state;
    w_head_from_in   = 1'b0;
    w_head_from_tail = 1'b0;
    w_tail_from_in   = 1'b0;
    case (r_rx_state)
      S_EMPTY: begin
        if (w_store) begin
          w_rx_state_nxt = S_ONE;
          w_head_from_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_store && !w_rx_pop) begin
          w_rx_state_nxt = S_TWO;
          w_tail_from_in = 1'b1;
        end else if (w_store && w_rx_pop) begin
          w_head_from_in = 1'b1;
        end else if (w_rx_pop) begin
          w_rx_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_rx_pop) begin
          w_rx_state_nxt   = S_ONE;
          w_head_from_tail = 1'b1;
        end
      end
      default: w_rx_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_head_from_in)        r_rx_head <= bus.mesh_in_flit[DATA_WIDTH-1:0];
    else if (w_head_from_tail) r_rx_head <= r_rx_tail;
    if (w_tail_from_in)        r_rx_tail <= bus.mesh_in_flit[DATA_WIDTH-1:0];
  end
endmodule

// File: tb/tb_edge_endpoint.sv
// Bench for edge_endpoint at X=1, Y=2, TX_DEPTH=4: vector table, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_edge_endpoint;
  localparam int CW = 4;
  localparam int DW = 32;
  localparam int FW = 2*CW + DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  edge_endpoint_if #(.COORD_WIDTH(CW), .DATA_WIDTH(DW), .TX_DEPTH(4)) bus ();

  edge_endpoint #(.X(1), .Y(2), .COORD_WIDTH(CW), .DATA_WIDTH(DW), .TX_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          tv;
    logic [FW-1:0] tflit;
    logic          mor;
    logic          miv;
    logic [FW-1:0] mflit;
    logic          rxr;
    logic          e_trdy;
    logic [2:0]    e_lvl;
    logic          e_mov;
    logic [FW-1:0] e_oflit;
    logic          e_mir;
    logic          e_rxv;
    logic [DW-1:0] e_rxd;
    logic [7:0]    e_drop;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [FW-1:0] fl(input int x, input int y, input logic [DW-1:0] d);
    return {CW'(x), CW'(y), d};
  endfunction

  function automatic vec_t mk(input logic tv, input logic [FW-1:0] tflit, input logic mor,
                              input logic miv, input logic [FW-1:0] mflit, input logic rxr,
                              input logic e_trdy, input int e_lvl, input logic e_mov,
                              input logic [FW-1:0] e_oflit, input logic e_mir,
                              input logic e_rxv, input logic [DW-1:0] e_rxd, input int e_drop);
    vec_t v;
    v.tv = tv; v.tflit = tflit; v.mor = mor; v.miv = miv; v.mflit = mflit; v.rxr = rxr;
    v.e_trdy = e_trdy; v.e_lvl = 3'(e_lvl); v.e_mov = e_mov; v.e_oflit = e_oflit;
    v.e_mir = e_mir; v.e_rxv = e_rxv; v.e_rxd = e_rxd; v.e_drop = 8'(e_drop);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic tv, input logic [FW-1:0] tflit, input logic mor,
                       input logic miv, input logic [FW-1:0] mflit, input logic rxr);
    bus.tx_valid       = tv;
    bus.tx_dst_x       = tflit[FW-1 -: CW];
    bus.tx_dst_y       = tflit[FW-CW-1 -: CW];
    bus.tx_data        = tflit[DW-1:0];
    bus.mesh_out_ready = mor;
    bus.mesh_in_valid  = miv;
    bus.mesh_in_flit   = mflit;
    bus.rx_ready       = rxr;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".tx_ready"}, 64'(bus.tx_ready), 64'd1);
    chk({tag, ".tx_level"}, 64'(bus.tx_level), 64'd0);
    chk({tag, ".mesh_out_valid"}, 64'(bus.mesh_out_valid), 64'd0);
    chk({tag, ".mesh_in_ready"}, 64'(bus.mesh_in_ready), 64'd1);
    chk({tag, ".rx_valid"}, 64'(bus.rx_valid), 64'd0);
    chk({tag, ".drop_count"}, 64'(bus.drop_count), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model: plain queues for the two buffers and an integer drop counter.
  logic [FW-1:0] m_tx[$];
  logic [DW-1:0] m_rx[$];
  int            m_drop;

  task automatic run_random(input int cycles);
    logic          tv = 1'b0, miv = 1'b0, mor, rxr;
    logic [FW-1:0] tflit = '0, mflit = '0;
    logic          tfire, ofire, ifire, rfire;
    m_tx.delete(); m_rx.delete(); m_drop = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (!tv) begin
        tv    = ($urandom_range(0, 3) != 0);
        tflit = {CW'($urandom), CW'($urandom), DW'($urandom)};
      end
      if (!miv) begin
        miv   = ($urandom_range(0, 2) != 0);
        mflit = ($urandom_range(0, 3) != 0) ? fl(1, 2, DW'($urandom))
                                            : {CW'($urandom), CW'($urandom), DW'($urandom)};
      end
      mor = ($urandom_range(0, 2) != 0);
      rxr = ($urandom_range(0, 2) != 0);
      drive(tv, tflit, mor, miv, mflit, rxr);
      #1;
      chk("rnd.tx_ready", 64'(bus.tx_ready), 64'(m_tx.size() < 4));
      chk("rnd.tx_level", 64'(bus.tx_level), 64'(m_tx.size()));
      chk("rnd.mesh_out_valid", 64'(bus.mesh_out_valid), 64'(m_tx.size() > 0));
      if (m_tx.size() > 0) chk("rnd.mesh_out_flit", 64'(bus.mesh_out_flit), 64'(m_tx[0]));
      chk("rnd.mesh_in_ready", 64'(bus.mesh_in_ready), 64'(m_rx.size() < 2));
      chk("rnd.rx_valid", 64'(bus.rx_valid), 64'(m_rx.size() > 0));
      if (m_rx.size() > 0) chk("rnd.rx_data", 64'(bus.rx_data), 64'(m_rx[0]));
      chk("rnd.drop_count", 64'(bus.drop_count), 64'(m_drop));
      tfire = tv && (m_tx.size() < 4);
      ofire = mor && (m_tx.size() > 0);
      ifire = miv && (m_rx.size() < 2);
      rfire = rxr && (m_rx.size() > 0);
      @(posedge clk);
      if (ofire) void'(m_tx.pop_front());
      if (tfire) m_tx.push_back(tflit);
      if (rfire) void'(m_rx.pop_front());
      if (ifire) begin
        if (mflit[FW-1 -: CW] == CW'(1) && mflit[FW-CW-1 -: CW] == CW'(2))
          m_rx.push_back(mflit[DW-1:0]);
        else if (m_drop < 255)
          m_drop++;
      end
      if (tfire) tv = 1'b0;
      if (ifire) miv = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    do_reset();
    #1 check_idle("reset");

    // TX burst with backpressure, then drain; followed by RX routing.
    for (int i = 0; i < 5; i++)
      tbl[i] = mk(1, fl(i, i+1, 32'h100+i), 0, 0, '0, 1,
                  (i < 4), i, (i > 0), fl(0, 1, 32'h100), 1, 0, '0, 0);
    tbl[5]  = mk(1, fl(4, 5, 32'h104), 1, 0, '0, 1, 0, 4, 1, fl(0, 1, 32'h100), 1, 0, '0, 0);
    tbl[6]  = mk(1, fl(4, 5, 32'h104), 1, 0, '0, 1, 1, 3, 1, fl(1, 2, 32'h101), 1, 0, '0, 0);
    tbl[7]  = mk(0, '0, 1, 0, '0, 1, 1, 3, 1, fl(2, 3, 32'h102), 1, 0, '0, 0);
    tbl[8]  = mk(0, '0, 1, 0, '0, 1, 1, 2, 1, fl(3, 4, 32'h103), 1, 0, '0, 0);
    tbl[9]  = mk(0, '0, 1, 0, '0, 1, 1, 1, 1, fl(4, 5, 32'h104), 1, 0, '0, 0);
    tbl[10] = mk(0, '0, 1, 0, '0, 1, 1, 0, 0, '0, 1, 0, '0, 0);
    tbl[11] = mk(0, '0, 1, 1, fl(1, 2, 32'hA), 1, 1, 0, 0, '0, 1, 0, '0, 0);
    tbl[12] = mk(0, '0, 1, 1, fl(3, 2, 32'hB), 1, 1, 0, 0, '0, 1, 1, 32'hA, 0);
    tbl[13] = mk(0, '0, 1, 1, fl(1, 2, 32'hC), 1, 1, 0, 0, '0, 1, 0, '0, 1);
    tbl[14] = mk(0, '0, 1, 0, '0, 1, 1, 0, 0, '0, 1, 1, 32'hC, 1);
    tbl[15] = mk(0, '0, 1, 0, '0, 1, 1, 0, 0, '0, 1, 0, '0, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].tv, tbl[i].tflit, tbl[i].mor, tbl[i].miv, tbl[i].mflit, tbl[i].rxr);
      #1;
      chk($sformatf("vec%0d.tx_ready", i), 64'(bus.tx_ready), 64'(tbl[i].e_trdy));
      chk($sformatf("vec%0d.tx_level", i), 64'(bus.tx_level), 64'(tbl[i].e_lvl));
      chk($sformatf("vec%0d.mesh_out_valid", i), 64'(bus.mesh_out_valid), 64'(tbl[i].e_mov));
      if (tbl[i].e_mov)
        chk($sformatf("vec%0d.mesh_out_flit", i), 64'(bus.mesh_out_flit), 64'(tbl[i].e_oflit));
      chk($sformatf("vec%0d.mesh_in_ready", i), 64'(bus.mesh_in_ready), 64'(tbl[i].e_mir));
      chk($sformatf("vec%0d.rx_valid", i), 64'(bus.rx_valid), 64'(tbl[i].e_rxv));
      if (tbl[i].e_rxv)
        chk($sformatf("vec%0d.rx_data", i), 64'(bus.rx_data), 64'(tbl[i].e_rxd));
      chk($sformatf("vec%0d.drop_count", i), 64'(bus.drop_count), 64'(tbl[i].e_drop));
    end

    // One-cycle TX latency.
    do_reset();
    @(negedge clk);
    drive(1'b1, fl(1, 2, 32'hDEADBEEF), 1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    #1;
    chk("lat.mesh_out_valid", 64'(bus.mesh_out_valid), 64'd1);
    chk("lat.mesh_out_flit", 64'(bus.mesh_out_flit), 64'h12DEADBEEF);
    chk("lat.tx_level", 64'(bus.tx_level), 64'd1);
    @(negedge clk);
    #1;
    chk("lat.tx_level_after", 64'(bus.tx_level), 64'd0);
    chk("lat.mesh_out_valid_after", 64'(bus.mesh_out_valid), 64'd0);

    // RX backpressure: third flit waits until the local side drains.
    do_reset();
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b1, fl(1, 2, 32'h11), 1'b0);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b1, fl(1, 2, 32'h22), 1'b0);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b1, fl(1, 2, 32'h33), 1'b0);
    #1;
    chk("bp.mesh_in_ready_full", 64'(bus.mesh_in_ready), 64'd0);
    chk("bp.rx_data0", 64'(bus.rx_data), 64'h11);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b1, fl(1, 2, 32'h33), 1'b1);
    #1;
    chk("bp.mesh_in_ready_still", 64'(bus.mesh_in_ready), 64'd0);
    chk("bp.rx_data1", 64'(bus.rx_data), 64'h11);
    @(negedge clk);
    #1;
    chk("bp.mesh_in_ready_open", 64'(bus.mesh_in_ready), 64'd1);
    chk("bp.rx_data2", 64'(bus.rx_data), 64'h22);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("bp.rx_valid3", 64'(bus.rx_valid), 64'd1);
    chk("bp.rx_data3", 64'(bus.rx_data), 64'h33);
    @(negedge clk);
    #1;
    chk("bp.rx_valid_empty", 64'(bus.rx_valid), 64'd0);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b1, fl(0, 0, 32'(i)), 1'b1);
      #1;
      if (i == 254) chk("sat.drop254", 64'(bus.drop_count), 64'd254);
      if (i == 255) chk("sat.drop255", 64'(bus.drop_count), 64'd255);
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("sat.drop_final", 64'(bus.drop_count), 64'd255);
    chk("sat.rx_valid", 64'(bus.rx_valid), 64'd0);

    // Asynchronous reset with TX level 3 and RX buffer full.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, fl(k, k, 32'h70+k), 1'b0, 1'b1,
            (k == 0) ? fl(0, 0, 32'h55) : fl(1, 2, 32'h60+k), 1'b0);
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("mid.tx_level_pre", 64'(bus.tx_level), 64'd3);
    chk("mid.mesh_in_ready_pre", 64'(bus.mesh_in_ready), 64'd0);
    chk("mid.drop_pre", 64'(bus.drop_count), 64'd1);
    #2 rst = 1'b0;
    #1 check_idle("midrst");
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the queue model.
    do_reset();
    run_random(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
